// File: rtl/pkg_tpu.sv
// Shared types for the public-domain request arbiter.
package pkg_tpu;

  typedef logic [31:0] address_t;
  typedef logic [1:0]  grant_no_t;

  localparam int unsigned NUM_PUB_REQ = 3;

  typedef enum logic [1:0] {
    PUB_IDLE = 2'd0,
    PUB_WAIT = 2'd1,
    PUB_XFER = 2'd2,
    PUB_END  = 2'd3
  } pub_state_t;

  // Round-robin successor over clients 0..2.
  function automatic grant_no_t rr_next(input grant_no_t no);
    return (no == 2'd2) ? 2'd0 : no + 2'd1;
  endfunction

endpackage

// File: rtl/pub_domain_arb_if.sv
// Store/load request and grant signals between the clients and the public-domain manager.
interface pub_domain_arb_if
  import pkg_tpu::*;
#(
  parameter int unsigned NUM_REQ   = NUM_PUB_REQ,
  parameter int unsigned WIDTH_LEN = 16
) ();

  logic [NUM_REQ-1:0]   I_St_Req,   I_Ld_Req;
  address_t             I_St_Base0, I_St_Base1, I_St_Base2;
  address_t             I_Ld_Base0, I_Ld_Base1, I_Ld_Base2;
  logic [WIDTH_LEN-1:0] I_St_Len0,  I_St_Len1,  I_St_Len2;
  logic [WIDTH_LEN-1:0] I_Ld_Len0,  I_Ld_Len1,  I_Ld_Len2;
  logic                 I_St_Ready, I_Ld_Ready;
  logic                 I_St_Beat,  I_Ld_Beat;

  logic [NUM_REQ-1:0]   O_St_Grant,   O_Ld_Grant;
  logic                 O_GrantVld_St, O_GrantVld_Ld;
  grant_no_t            O_GrantNo_St, O_GrantNo_Ld;
  address_t             O_St_Base,    O_Ld_Base;
  logic                 O_St_End,     O_Ld_End;
  logic                 O_St_Busy,    O_Ld_Busy;

  modport master (
    output I_St_Req, I_St_Base0, I_St_Base1, I_St_Base2, I_St_Len0, I_St_Len1, I_St_Len2,
           I_St_Ready, I_St_Beat,
           I_Ld_Req, I_Ld_Base0, I_Ld_Base1, I_Ld_Base2, I_Ld_Len0, I_Ld_Len1, I_Ld_Len2,
           I_Ld_Ready, I_Ld_Beat,
    input  O_St_Grant, O_GrantVld_St, O_GrantNo_St, O_St_Base, O_St_End, O_St_Busy,
           O_Ld_Grant, O_GrantVld_Ld, O_GrantNo_Ld, O_Ld_Base, O_Ld_End, O_Ld_Busy
  );

  modport slave (
    input  I_St_Req, I_St_Base0, I_St_Base1, I_St_Base2, I_St_Len0, I_St_Len1, I_St_Len2,
           I_St_Ready, I_St_Beat,
           I_Ld_Req, I_Ld_Base0, I_Ld_Base1, I_Ld_Base2, I_Ld_Len0, I_Ld_Len1, I_Ld_Len2,
           I_Ld_Ready, I_Ld_Beat,
    output O_St_Grant, O_GrantVld_St, O_GrantNo_St, O_St_Base, O_St_End, O_St_Busy,
           O_Ld_Grant, O_GrantVld_Ld, O_GrantNo_Ld, O_Ld_Base, O_Ld_End, O_Ld_Busy
  );

endinterface

// File: rtl/pub_dir_arb.sv
// Single-direction round-robin arbiter: owner selection, grant hold, beat counting, end pulse.
module pub_dir_arb
  import pkg_tpu::*;
#(
  parameter int unsigned NUM_REQ   = NUM_PUB_REQ,
  parameter int unsigned WIDTH_LEN = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NUM_REQ-1:0]   req,
  input  address_t             base0,
  input  address_t             base1,
  input  address_t             base2,
  input  logic [WIDTH_LEN-1:0] len0,
  input  logic [WIDTH_LEN-1:0] len1,
  input  logic [WIDTH_LEN-1:0] len2,
  input  logic                 ready,
  input  logic                 beat,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_vld,
  output grant_no_t            grant_no,
  output address_t             base_out,
  output logic                 xfer_end,
  output logic                 busy
);

  localparam logic [WIDTH_LEN-1:0] LEN_ONE = WIDTH_LEN'(1);

  pub_state_t           state;
  grant_no_t            r_last, no_q, c1, c2, win;
  address_t             base_q, sel_base;
  logic [WIDTH_LEN-1:0] len_q, cnt, sel_len;

  // Priority order after the last owner: last+1, last+2, then last itself.
  always_comb begin
    c1  = rr_next(r_last);
    c2  = rr_next(c1);
    win = r_last;
    if (req[c1])      win = c1;
    else if (req[c2]) win = c2;
    sel_base = base2;
    sel_len  = len2;
    case (win)
      2'd0:    begin sel_base = base0; sel_len = len0; end
      2'd1:    begin sel_base = base1; sel_len = len1; end
      default: begin sel_base = base2; sel_len = len2; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= PUB_IDLE;
      r_last <= 2'd2;
      no_q   <= '0;
      base_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
    end else if (!stall) begin
      case (state)
        PUB_IDLE: if (|req) begin
          no_q   <= win;
          base_q <= sel_base;
          len_q  <= (sel_len == '0) ? LEN_ONE : sel_len;
          r_last <= win;
          state  <= PUB_WAIT;
        end
        PUB_WAIT: if (ready) begin
          cnt   <= len_q;
          state <= PUB_XFER;
        end
        PUB_XFER: if (beat) begin
          cnt <= cnt - LEN_ONE;
          if (cnt == LEN_ONE) state <= PUB_END;
        end
        default: state <= PUB_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only; IDLE forces every grant output low.
  always_comb begin
    busy      = (state != PUB_IDLE);
    grant_vld = (state == PUB_WAIT);
    xfer_end  = (state == PUB_END);
    grant     = '0;
    grant_no  = '0;
    base_out  = '0;
    if (busy) begin
      grant[no_q] = 1'b1;
      grant_no    = no_q;
      base_out    = base_q;
    end
  end

endmodule

// File: rtl/pub_domain_arb.sv
// Store and load request arbiters in front of the public-domain manager; only stall is shared.
module pub_domain_arb
  import pkg_tpu::*;
#(
  parameter int unsigned NUM_REQ   = NUM_PUB_REQ,
  parameter int unsigned WIDTH_LEN = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Stall,
  pub_domain_arb_if.slave  bus
);

  pub_dir_arb #(.NUM_REQ(NUM_REQ), .WIDTH_LEN(WIDTH_LEN)) u_st (
    .clock     (clock),
    .reset     (reset),
    .stall     (I_Stall),
    .req       (bus.I_St_Req),
    .base0     (bus.I_St_Base0),
    .base1     (bus.I_St_Base1),
    .base2     (bus.I_St_Base2),
    .len0      (bus.I_St_Len0),
    .len1      (bus.I_St_Len1),
    .len2      (bus.I_St_Len2),
    .ready     (bus.I_St_Ready),
    .beat      (bus.I_St_Beat),
    .grant     (bus.O_St_Grant),
    .grant_vld (bus.O_GrantVld_St),
    .grant_no  (bus.O_GrantNo_St),
    .base_out  (bus.O_St_Base),
    .xfer_end  (bus.O_St_End),
    .busy      (bus.O_St_Busy)
  );

  pub_dir_arb #(.NUM_REQ(NUM_REQ), .WIDTH_LEN(WIDTH_LEN)) u_ld (
    .clock     (clock),
    .reset     (reset),
    .stall     (I_Stall),
    .req       (bus.I_Ld_Req),
    .base0     (bus.I_Ld_Base0),
    .base1     (bus.I_Ld_Base1),
    .base2     (bus.I_Ld_Base2),
    .len0      (bus.I_Ld_Len0),
    .len1      (bus.I_Ld_Len1),
    .len2      (bus.I_Ld_Len2),
    .ready     (bus.I_Ld_Ready),
    .beat      (bus.I_Ld_Beat),
    .grant     (bus.O_Ld_Grant),
    .grant_vld (bus.O_GrantVld_Ld),
    .grant_no  (bus.O_GrantNo_Ld),
    .base_out  (bus.O_Ld_Base),
    .xfer_end  (bus.O_Ld_End),
    .busy      (bus.O_Ld_Busy)
  );

endmodule

// File: tb/tb_pub_domain_arb.sv
// Directed and random checks of pub_domain_arb against a transaction-level reference model.
module tb_pub_domain_arb;
  import pkg_tpu::*;

  logic clock = 1'b0;
  logic reset;
  logic I_Stall;
  always #5 clock = ~clock;

  pub_domain_arb_if #(.NUM_REQ(3), .WIDTH_LEN(16)) bus ();

  pub_domain_arb #(.NUM_REQ(3), .WIDTH_LEN(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .I_Stall (I_Stall),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus, index 0 = store, 1 = load.
  logic [2:0]  s_req  [2];
  logic [31:0] s_base [2][3];
  logic [15:0] s_len  [2][3];
  logic        s_ready[2];
  logic        s_beat [2];

  // Reference model: current owner (-1 none), whether it still awaits ready,
  // beats outstanding, whether the end cycle is showing, last winner.
  int          m_owner[2];
  bit          m_wait [2];
  bit          m_end  [2];
  int          m_left [2];
  int          m_len  [2];
  int          m_last [2];
  logic [31:0] m_base [2];
  int          cyc;

  task automatic clear_inputs();
    I_Stall = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_req[d] = '0; s_ready[d] = 1'b0; s_beat[d] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s_base[d][k] = 32'h1000_0000 * (k + 1) + 32'h100 * d;
        s_len[d][k]  = 16'd1;
      end
    end
  endtask

  task automatic apply();
    bus.I_St_Req = s_req[0];  bus.I_St_Ready = s_ready[0]; bus.I_St_Beat = s_beat[0];
    bus.I_St_Base0 = s_base[0][0]; bus.I_St_Base1 = s_base[0][1]; bus.I_St_Base2 = s_base[0][2];
    bus.I_St_Len0 = s_len[0][0];   bus.I_St_Len1 = s_len[0][1];   bus.I_St_Len2 = s_len[0][2];
    bus.I_Ld_Req = s_req[1];  bus.I_Ld_Ready = s_ready[1]; bus.I_Ld_Beat = s_beat[1];
    bus.I_Ld_Base0 = s_base[1][0]; bus.I_Ld_Base1 = s_base[1][1]; bus.I_Ld_Base2 = s_base[1][2];
    bus.I_Ld_Len0 = s_len[1][0];   bus.I_Ld_Len1 = s_len[1][1];   bus.I_Ld_Len2 = s_len[1][2];
  endtask

  task automatic model_step(input int d);
    int pick;
    if (reset) begin
      m_owner[d] = -1; m_wait[d] = 0; m_end[d] = 0; m_left[d] = 0; m_last[d] = 2;
    end else if (!I_Stall) begin
      if (m_owner[d] < 0) begin
        pick = -1;
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last[d] + k) % 3;
          if (pick < 0 && s_req[d][c]) pick = c;
        end
        if (pick >= 0) begin
          m_owner[d] = pick;
          m_last[d]  = pick;
          m_base[d]  = s_base[d][pick];
          m_len[d]   = (s_len[d][pick] == 0) ? 1 : int'(s_len[d][pick]);
          m_wait[d]  = 1;
        end
      end else if (m_end[d]) begin
        m_owner[d] = -1;
        m_end[d]   = 0;
      end else if (m_wait[d]) begin
        if (s_ready[d]) begin
          m_wait[d] = 0;
          m_left[d] = m_len[d];
        end
      end else if (s_beat[d]) begin
        m_left[d]--;
        if (m_left[d] == 0) m_end[d] = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      string p;
      bit    own;
      p   = (d == 0) ? "st" : "ld";
      own = (m_owner[d] >= 0);
      check_eq({p, "_grant"}, (d == 0) ? bus.O_St_Grant : bus.O_Ld_Grant,
               own ? (64'd1 << m_owner[d]) : 64'd0);
      check_eq({p, "_vld"}, (d == 0) ? bus.O_GrantVld_St : bus.O_GrantVld_Ld,
               64'(own && m_wait[d]));
      check_eq({p, "_no"}, (d == 0) ? bus.O_GrantNo_St : bus.O_GrantNo_Ld,
               own ? 64'(m_owner[d]) : 64'd0);
      check_eq({p, "_base"}, (d == 0) ? bus.O_St_Base : bus.O_Ld_Base,
               own ? 64'(m_base[d]) : 64'd0);
      check_eq({p, "_end"}, (d == 0) ? bus.O_St_End : bus.O_Ld_End, 64'(m_end[d]));
      check_eq({p, "_busy"}, (d == 0) ? bus.O_St_Busy : bus.O_Ld_Busy, 64'(own));
    end
  endtask

  task automatic tick();
    apply();
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
    compare_all();
    cyc++;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  int nos[$];
  int st_end_cyc, ld_end_cyc;

  initial begin
    reset = 1'b1;
    cyc   = 0;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_wait[d] = 0; m_end[d] = 0; m_left[d] = 0; m_last[d] = 2;
      m_len[d] = 0; m_base[d] = '0;
    end
    clear_inputs();
    tick();
    do_reset();
    check_eq("rst_st_grant", bus.O_St_Grant, 3'b000);
    check_eq("rst_ld_busy",  bus.O_Ld_Busy, 1'b0);

    // Single store, Len 4, ready in cycle 2, beats every cycle.
    s_req[0] = 3'b001; s_len[0][0] = 16'd4; s_base[0][0] = 32'hA000_0040;
    tick();
    check_eq("t1_grant_c1", bus.O_St_Grant, 3'b001);
    check_eq("t1_no_c1", bus.O_GrantNo_St, 2'd0);
    s_req[0] = 3'b000;
    tick();
    s_ready[0] = 1'b1; s_beat[0] = 1'b1;
    tick();
    s_ready[0] = 1'b0;
    repeat (4) tick();
    check_eq("t1_end_c7", bus.O_St_End, 1'b1);
    check_eq("t1_grant_c7", bus.O_St_Grant, 3'b001);
    tick();
    check_eq("t1_grant_c8", bus.O_St_Grant, 3'b000);
    check_eq("t1_end_c8", bus.O_St_End, 1'b0);

    // All clients requesting, Len 1: order 0,1,2,0 every 4 cycles.
    do_reset();
    s_req[0] = 3'b111; s_ready[0] = 1'b1; s_beat[0] = 1'b1;
    nos.delete();
    repeat (16) begin
      tick();
      if (bus.O_GrantVld_St) nos.push_back(int'(bus.O_GrantNo_St));
    end
    check_eq("t2_ngrants", nos.size(), 4);
    for (int i = 0; i < nos.size() && i < 4; i++)
      check_eq($sformatf("t2_order%0d", i), nos[i], (i == 3) ? 0 : i);

    // Len 0 behaves as a single beat.
    clear_inputs();
    s_req[0] = 3'b010; s_len[0][1] = 16'd0; s_ready[0] = 1'b1;
    tick();
    tick();
    s_ready[0] = 1'b0;
    tick();
    tick();
    check_eq("t3_noend_nobeat", bus.O_St_End, 1'b0);
    s_beat[0] = 1'b1;
    tick();
    check_eq("t3_end_one_beat", bus.O_St_End, 1'b1);
    clear_inputs();
    tick();

    // Stall in WAIT and in END.
    s_req[0] = 3'b001; s_len[0][0] = 16'd2;
    tick();
    I_Stall = 1'b1; s_ready[0] = 1'b1;
    repeat (5) begin
      tick();
      check_eq("t4_vld_stall", bus.O_GrantVld_St, 1'b1);
    end
    I_Stall = 1'b0;
    tick();
    s_ready[0] = 1'b0; s_beat[0] = 1'b1;
    tick();
    tick();
    check_eq("t4_end", bus.O_St_End, 1'b1);
    I_Stall = 1'b1; s_beat[0] = 1'b0;
    repeat (5) begin
      tick();
      check_eq("t4_end_stall", bus.O_St_End, 1'b1);
    end
    I_Stall = 1'b0; s_req[0] = 3'b000;
    tick();
    check_eq("t4_end_after", bus.O_St_End, 1'b0);

    // Simultaneous store (client 2, Len 3) and load (client 0, Len 2).
    do_reset();
    s_req[0] = 3'b100; s_len[0][2] = 16'd3;
    s_req[1] = 3'b001; s_len[1][0] = 16'd2;
    s_ready[0] = 1'b1; s_ready[1] = 1'b1; s_beat[0] = 1'b1; s_beat[1] = 1'b1;
    st_end_cyc = -1; ld_end_cyc = -1;
    repeat (10) begin
      tick();
      if (bus.O_St_End && st_end_cyc < 0) st_end_cyc = cyc;
      if (bus.O_Ld_End && ld_end_cyc < 0) ld_end_cyc = cyc;
    end
    check_eq("t5_ld_end_cyc", ld_end_cyc, 4);
    check_eq("t5_st_end_cyc", st_end_cyc, 5);

    // Reset during XFER with two beats outstanding.
    do_reset();
    s_req[0] = 3'b010; s_len[0][1] = 16'd3; s_ready[0] = 1'b1;
    tick();
    tick();
    s_ready[0] = 1'b0; s_beat[0] = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_eq("t6_grant_rst", bus.O_St_Grant, 3'b000);
    check_eq("t6_end_rst", bus.O_St_End, 1'b0);
    reset = 1'b0; s_req[0] = 3'b111; s_beat[0] = 1'b0;
    tick();
    check_eq("t6_regrant_no", bus.O_GrantNo_St, 2'd0);

    // Random traffic on both directions.
    do_reset();
    repeat (3000) begin
      reset   = ($urandom_range(0, 299) == 0);
      I_Stall = ($urandom_range(0, 15) == 0);
      for (int d = 0; d < 2; d++) begin
        s_req[d]   = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        s_ready[d] = $urandom_range(0, 1) != 0;
        s_beat[d]  = $urandom_range(0, 2) != 0;
        for (int k = 0; k < 3; k++) begin
          s_base[d][k] = $urandom;
          s_len[d][k]  = 16'($urandom_range(0, 4));
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
